// File: rtl/ring_sweep_ctrl.sv
// rtl/ring_sweep_ctrl.sv - ring-oscillator bank measurement sequencer
//
// Steps one-hot through the enabled rings (highest index first). Each ring is
// held selected for a settle period, then the grey event counters are
// cleared, gated for a fixed window, and the frozen grey count is captured.
// The captured count is converted to binary and reported with its ring index.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_start    start a sweep (level-sampled while idle)
//   i_stop     abort the sweep in progress
//   i_cont     continuous mode: wrap to the highest ring after the lowest
//   i_mask     ring enable mask, bit n = ring n
//   i_cnt      grey-coded count from the counter chain
//   o_sel      one-hot ring select, zero when no ring is selected
//   o_cnt_clr  counter clear, one cycle
//   o_cnt_en   counter gate, pWINDOW cycles
//   o_busy     sweep in progress
//   o_valid    result strobe, one cycle
//   o_idx      ring index of o_result
//   o_result   binary count
//   o_done     end-of-sweep pulse, coincides with the final o_valid
module ring_sweep_ctrl #(
   parameter int pRINGS  = 6,
   parameter int pCNT_W  = 10,
   parameter int pSETTLE = 16,
   parameter int pWINDOW = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_cont,
   input  logic [pRINGS-1:0] i_mask,
   input  logic [pCNT_W-1:0] i_cnt,
   output logic [pRINGS-1:0] o_sel,
   output logic              o_cnt_clr,
   output logic              o_cnt_en,
   output logic              o_busy,
   output logic              o_valid,
   output logic [2:0]        o_idx,
   output logic [pCNT_W-1:0] o_result,
   output logic              o_done
);

   localparam int SW = $clog2(pSETTLE + 1);
   localparam int WW = $clog2(pWINDOW + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(pSETTLE - 1);
   localparam logic [WW-1:0] WINDOW_LAST = WW'(pWINDOW - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      CLEAR  = 3'd2,
      COUNT  = 3'd3,
      LATCH  = 3'd4,
      NEXT   = 3'd5
   } state_t;

   state_t              state, state_nx;
   logic [2:0]          idx, idx_nx;
   logic [pRINGS-1:0]   mask_q, mask_nx;
   logic [SW-1:0]       settle_q, settle_nx;
   logic [WW-1:0]       win_q, win_nx;
   logic                finish_q, finish_nx;

   logic [pRINGS-1:0]   sel_nx;
   logic                clr_nx, en_nx, busy_nx, valid_nx, done_nx;
   logic [2:0]          ridx_nx;
   logic [pCNT_W-1:0]   result_nx;

   // {found, index} of the highest set bit of m strictly below lim
   function automatic logic [3:0] find_below(input logic [pRINGS-1:0] m, input int lim);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < pRINGS; i++) begin
         if (m[i] && (i < lim)) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   function automatic logic [pRINGS-1:0] onehot(input logic [2:0] n);
      logic [pRINGS-1:0] one;
      one    = '0;
      one[0] = 1'b1;
      return one << n;
   endfunction

   function automatic logic [pCNT_W-1:0] grey2bin(input logic [pCNT_W-1:0] g);
      logic [pCNT_W-1:0] b;
      b[pCNT_W-1] = g[pCNT_W-1];
      for (int k = pCNT_W - 2; k >= 0; k--) begin
         b[k] = b[k+1] ^ g[k];
      end
      return b;
   endfunction

   logic [3:0] lo_hit;   // next lower ring in the latched mask
   logic [3:0] hi_new;   // highest ring in the live mask (start / wrap)

   assign lo_hit = find_below(mask_q, int'(idx));
   assign hi_new = find_below(i_mask, pRINGS);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         idx      <= '0;
         mask_q   <= '0;
         settle_q <= '0;
         win_q    <= '0;
         finish_q <= 1'b0;
         o_sel    <= '0;
         o_cnt_clr<= 1'b0;
         o_cnt_en <= 1'b0;
         o_busy   <= 1'b0;
         o_valid  <= 1'b0;
         o_idx    <= '0;
         o_result <= '0;
         o_done   <= 1'b0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         mask_q   <= mask_nx;
         settle_q <= settle_nx;
         win_q    <= win_nx;
         finish_q <= finish_nx;
         o_sel    <= sel_nx;
         o_cnt_clr<= clr_nx;
         o_cnt_en <= en_nx;
         o_busy   <= busy_nx;
         o_valid  <= valid_nx;
         o_idx    <= ridx_nx;
         o_result <= result_nx;
         o_done   <= done_nx;
      end
   end

   // Outputs are computed for the state being entered and registered on the
   // same edge, so every output lines up with its state without any
   // combinational path from the inputs.
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      mask_nx   = mask_q;
      settle_nx = settle_q;
      win_nx    = win_q;
      finish_nx = finish_q;
      sel_nx    = o_sel;
      clr_nx    = 1'b0;
      en_nx     = 1'b0;
      valid_nx  = 1'b0;
      done_nx   = 1'b0;
      ridx_nx   = o_idx;
      result_nx = o_result;

      case (state)
         IDLE: begin
            sel_nx = '0;
            if (i_start && !i_stop && (i_mask != '0)) begin
               mask_nx   = i_mask;
               idx_nx    = hi_new[2:0];
               sel_nx    = onehot(hi_new[2:0]);
               settle_nx = '0;
               state_nx  = SELECT;
            end
         end
         SELECT: begin
            if (settle_q == SETTLE_LAST) begin
               clr_nx   = 1'b1;
               state_nx = CLEAR;
            end else begin
               settle_nx = settle_q + 1'b1;
            end
         end
         CLEAR: begin
            en_nx    = 1'b1;
            win_nx   = '0;
            state_nx = COUNT;
         end
         COUNT: begin
            if (win_q == WINDOW_LAST) begin
               state_nx = LATCH;
            end else begin
               en_nx  = 1'b1;
               win_nx = win_q + 1'b1;
            end
         end
         LATCH: begin
            // The next-ring decision is taken here so that o_done can be
            // registered alongside o_valid.
            result_nx = grey2bin(i_cnt);
            ridx_nx   = idx;
            valid_nx  = 1'b1;
            state_nx  = NEXT;
            if (lo_hit[3]) begin
               idx_nx    = lo_hit[2:0];
               finish_nx = 1'b0;
            end else if (i_cont && hi_new[3]) begin
               mask_nx   = i_mask;
               idx_nx    = hi_new[2:0];
               finish_nx = 1'b0;
            end else begin
               finish_nx = 1'b1;
               done_nx   = 1'b1;
            end
         end
         NEXT: begin
            if (finish_q) begin
               sel_nx   = '0;
               state_nx = IDLE;
            end else begin
               sel_nx    = onehot(idx);
               settle_nx = '0;
               state_nx  = SELECT;
            end
         end
         default: begin
            sel_nx   = '0;
            state_nx = IDLE;
         end
      endcase

      // Abort: drop everything on the next edge; a result already strobed
      // stays in o_result.
      if (i_stop && (state != IDLE)) begin
         state_nx  = IDLE;
         mask_nx   = mask_q;
         sel_nx    = '0;
         clr_nx    = 1'b0;
         en_nx     = 1'b0;
         valid_nx  = 1'b0;
         done_nx   = 1'b0;
         ridx_nx   = o_idx;
         result_nx = o_result;
      end

      busy_nx = (state_nx != IDLE);
   end

endmodule

// File: tb/tb_ring_sweep_ctrl.sv
// tb/tb_ring_sweep_ctrl.sv - self-checking bench for ring_sweep_ctrl
module tb_ring_sweep_ctrl;

   localparam int S = 4;
   localparam int W = 8;
   localparam int P = S + W + 3;

   logic       clk = 1'b0;
   logic       i_rst, i_start, i_stop, i_cont;
   logic [5:0] i_mask;
   logic [9:0] i_cnt;
   logic [5:0] o_sel;
   logic       o_cnt_clr, o_cnt_en, o_busy, o_valid, o_done;
   logic [2:0] o_idx;
   logic [9:0] o_result;

   int total = 0;
   int bad   = 0;
   int gap;

   ring_sweep_ctrl #(.pRINGS(6), .pCNT_W(10), .pSETTLE(S), .pWINDOW(W)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
      .i_cont(i_cont), .i_mask(i_mask), .i_cnt(i_cnt),
      .o_sel(o_sel), .o_cnt_clr(o_cnt_clr), .o_cnt_en(o_cnt_en),
      .o_busy(o_busy), .o_valid(o_valid), .o_idx(o_idx),
      .o_result(o_result), .o_done(o_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] gray(input logic [9:0] n);
      return n ^ (n >> 1);
   endfunction

   function automatic logic [5:0] onehot(input int n);
      logic [5:0] r;
      r = 6'd1 << n;
      return r;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_sel"},   32'(o_sel), 0);
      check({tag, "_clr"},   32'(o_cnt_clr), 0);
      check({tag, "_en"},    32'(o_cnt_en), 0);
      check({tag, "_busy"},  32'(o_busy), 0);
      check({tag, "_valid"}, 32'(o_valid), 0);
      check({tag, "_done"},  32'(o_done), 0);
   endtask

   // Steps until o_valid (bounded); gap = number of steps taken.
   task automatic wait_valid(input string tag);
      int n;
      step();
      n = 1;
      while (o_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      gap = n;
      check({tag, "_seen"}, 32'(o_valid), 1);
   endtask

   // One non-continuous sweep, checked cycle by cycle against the timing
   // laid out from settle/window lengths and the descending ring order.
   task automatic run_sweep(input logic [5:0] m, input bit fixed, input logic [9:0] fv,
                            input bit disturb);
      int         order[$];
      logic [9:0] vals[$];
      int         k, j, p;
      for (int b = 5; b >= 0; b--) if (m[b]) order.push_back(b);
      k = order.size();
      for (int q = 0; q < k; q++) vals.push_back(fixed ? fv : 10'($urandom_range(0, 1023)));
      i_mask  = m;
      i_cont  = 1'b0;
      i_cnt   = gray(vals[0]);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int c = 1; c <= P * k; c++) begin
         j = (c - 1) / P;
         p = (c - 1) % P + 1;
         if (p == 1) i_cnt = gray(vals[j]);
         if (disturb && c == 3) i_mask = 6'($urandom);
         if (p != P) check("sw_sel", 32'(o_sel), 32'(onehot(order[j])));
         check("sw_clr", 32'(o_cnt_clr), 32'(p == S + 1));
         check("sw_en", 32'(o_cnt_en), 32'(p >= S + 2 && p <= S + 1 + W));
         check("sw_valid", 32'(o_valid), 32'(p == P));
         check("sw_busy", 32'(o_busy), 1);
         if (p == P) begin
            check("sw_idx", 32'(o_idx), 32'(order[j]));
            check("sw_result", 32'(o_result), 32'(vals[j]));
            check("sw_done", 32'(o_done), 32'(j == k - 1));
         end else begin
            check("sw_done_lo", 32'(o_done), 0);
         end
         step();
      end
      check_quiet("sw_end");
      check("sw_hold", 32'(o_result), 32'(vals[k-1]));
   endtask

   initial begin
      int exp_idx[7];
      i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_cont = 1'b0;
      i_mask = '0;  i_cnt = '0;
      step(); step();
      check_quiet("rst");
      check("rst_idx", 32'(o_idx), 0);
      check("rst_result", 32'(o_result), 0);
      i_rst = 1'b0;
      step();

      // single ring, grey 0000000111 -> 5
      run_sweep(6'b000010, 1'b1, 10'd5, 1'b0);
      check("single_idx", 32'(o_idx), 1);
      step();

      // sweep order 5,3,0
      run_sweep(6'b101001, 1'b0, 10'd0, 1'b0);
      step();

      // random masks, mask disturbed mid-sweep
      for (int r = 0; r < 6; r++) begin
         run_sweep(6'($urandom_range(1, 63)), 1'b0, 10'd0, 1'b1);
         step();
      end

      // continuous mode with mask edits
      exp_idx = '{1, 0, 1, 0, 1, 1, 1};
      i_mask = 6'b000011; i_cont = 1'b1; i_cnt = gray(10'd77);
      i_start = 1'b1; step(); i_start = 1'b0;
      for (int v = 0; v < 7; v++) begin
         wait_valid("cont");
         check("cont_gap", 32'(gap), (v == 0) ? 14 : P);
         check("cont_idx", 32'(o_idx), 32'(exp_idx[v]));
         check("cont_result", 32'(o_result), 77);
         check("cont_done", 32'(o_done), 32'(v == 6));
         if (v == 2) i_mask = 6'b000010;
         if (v == 5) i_mask = 6'b000000;
      end
      step();
      check("cont_end_busy", 32'(o_busy), 0);
      i_cont = 1'b0;
      step();

      // abort during COUNT
      i_mask = 6'b101001; i_start = 1'b1; step(); i_start = 1'b0;
      for (int c = 1; c < S + 3; c++) step();
      check("abort_pre_en", 32'(o_cnt_en), 1);
      i_stop = 1'b1;
      step();
      i_stop = 1'b0;
      check_quiet("abort");
      for (int c = 0; c < 2 * P; c++) begin
         step();
         check("abort_novalid", 32'(o_valid | o_busy), 0);
      end

      // start with empty mask; start together with stop
      i_mask = 6'b000000; i_start = 1'b1; step(); step();
      check("zero_mask_busy", 32'(o_busy), 0);
      i_mask = 6'b000100; i_stop = 1'b1; step(); step();
      check("stop_start_busy", 32'(o_busy), 0);
      check("stop_start_sel", 32'(o_sel), 0);
      i_start = 1'b0; i_stop = 1'b0;
      step();

      // reset during LATCH
      i_mask = 6'b000001; i_cnt = gray(10'h2ab); i_start = 1'b1; step(); i_start = 1'b0;
      for (int c = 1; c < P - 1; c++) step();
      i_rst = 1'b1;
      step();
      check_quiet("rst_latch");
      check("rst_latch_result", 32'(o_result), 0);
      check("rst_latch_idx", 32'(o_idx), 0);
      i_rst = 1'b0;
      step();
      run_sweep(6'b000100, 1'b1, 10'h155, 1'b0);
      step();

      // full grey decode sweep through the measurement path
      i_mask = 6'b000001; i_cont = 1'b1; i_cnt = gray(10'd0);
      i_start = 1'b1; step(); i_start = 1'b0;
      for (int n = 0; n < 1024; n++) begin
         wait_valid("grey");
         check("grey_result", 32'(o_result), 32'(n));
         i_cnt = gray(10'(n + 1));
      end
      i_cont = 1'b0;
      wait_valid("grey_end");
      check("grey_end_done", 32'(o_done), 1);
      step();
      check("grey_end_busy", 32'(o_busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
